// File: rtl/fifo_ctrl_mem.sv
// Synchronous FIFO with owned pointers, occupancy count and full/empty/almost flags.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_EN.
module fifo_ctrl_mem #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3,
    parameter int unsigned AF_TH     = 6,
    parameter int unsigned AE_TH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 rd_acc, wr_acc;

    // Flags decode the count register only, so no input reaches an output combinationally.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_TH));
    assign almost_empty = (count_q <= CNT_W'(AE_TH));

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_acc = read && !empty;
    assign wr_acc = write && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end
        if (rd_acc) begin
            rd_ptr_d    = rd_ptr_q + ADDR_SIZE'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign count     = count_q;

`ifdef FIFO_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    always_comb begin
        err_ovf_d = err_ovf_q || (write && full && !rd_acc);
        err_unf_d = err_unf_q || (read && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule
